seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexing scan controller for the 4-digit seven-segment display on the board. It owns the hex-to-segment decode and the shared segment bus. It rotates one active-low anode at a time through digits A–D at a programmable refresh rate, with optional blanking gaps between digits. Digit values are double-buffered: a new value set is committed only at a frame boundary, so a frame never shows a mix of old and new digits.

## Interface
- `DIGIT_TICKS`, default 100000: clock cycles each digit is lit (≥1).
- `BLANK_TICKS`, default 1000: clock cycles of all-off gap after each digit (≥1). Used only with `SEG_SCAN_BLANK_EN`.
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  level; high = scan, low = display dark.
- `load`  in  1  one-cycle strobe; capture `din_a`..`din_d`.
- `din_a`, `din_b`, `din_c`, `din_d`  in  4 each  hex digit values; A is leftmost.
- `seg`  out  7  segment cathodes, active-low, bit 6 = g … bit 0 = a.
- `anode`  out  4  digit enables, active-low; A→`anode[3]`, B→`[2]`, C→`[1]`, D→`[0]`.
- `digit_sel`  out  2  index of lit or most recently lit digit (0 = A … 3 = D).
- `frame_done`  out  1  one-cycle pulse at each frame boundary.

## Operation
- Registers: `pend[4]`, `pend_valid`, `disp[4]`, tick counter, state ∈ {IDLE, SHOW, BLANK}.
- Counter width is `$clog2(max(DIGIT_TICKS,BLANK_TICKS)+1)`. The counter reloads to 0 on every state or digit change and never wraps inside a slot.
- IDLE:
  - `anode`=4'hF, `seg`=7'h7F.
  - `load` writes `disp` directly.
  - When `enable`=1: go to SHOW with digit 0 and counter 0.
- SHOW:
  - `anode` has a single 0 at the position for `digit_sel`.
  - `seg` = decode(`disp[digit_sel]`).
  - Decode table (index `gfedcba`): 0 1000000, 1 1111001, 2 0100100, 3 0110000, 4 0011001, 5 0010010, 6 0000010, 7 1111000, 8 0000000, 9 0010000, A 0001000, b 0000011, C 1000110, d 0100001, E 0000110, F 0001110.
  - After `DIGIT_TICKS` cycles: go to BLANK if the macro is defined, otherwise advance the digit.
- BLANK:
  - `anode`=4'hF, `seg`=7'h7F, `digit_sel` held.
  - After `BLANK_TICKS` cycles: advance the digit.
- Digit advance: `digit_sel` goes 0→1→2→3→0 and the state returns to SHOW.
- Frame boundary (advance from digit 3 back to 0):
  - `frame_done`=1 for one cycle.
  - If `pend_valid`: `disp`←`pend`, `pend_valid`←0.
- `load` outside IDLE: `pend`←din, `pend_valid`←1. A later load before the boundary overwrites `pend`.
- `load` in the same cycle as a frame boundary: `disp`←din directly (new data wins), `pend_valid`←0.
- `enable` low in SHOW or BLANK:
  - Next edge goes to IDLE and outputs go dark.
  - `pend` is committed to `disp` on entry to IDLE.
  - Re-enable always restarts at digit A.

## Timing
- All outputs are registered and update on the same edge as the state change.
- Reset values (asynchronous on `rst_n` low):
  - Outputs: `seg`=7'h7F, `anode`=4'hF, `digit_sel`=0, `frame_done`=0.
  - Internal: `disp`=0, `pend`=0, `pend_valid`=0, state IDLE.
- `enable` sampled high at edge k: after edge k, `anode`=4'b0111 with digit A decode.
- Frame period:
  - With macro: 4·(`DIGIT_TICKS`+`BLANK_TICKS`).
  - Without macro: 4·`DIGIT_TICKS`.
- `frame_done` is high in the first cycle of the next frame's digit-A slot.
- Commit latency: a load is visible at the next frame boundary, at most one frame period. In IDLE, it is visible one cycle after the load.
- Only one `anode` bit is ever low. No cycle drives a lit anode together with the previous digit's segments.
- Reset asserted mid-slot: outputs go dark immediately, with no clock required.

## Configuration
- `SEG_SCAN_BLANK_EN` defined:
  - BLANK state and `BLANK_TICKS` are compiled in.
  - An all-off gap follows every digit, suppressing ghosting.
- `SEG_SCAN_BLANK_EN` not defined:
  - No BLANK state; `BLANK_TICKS` is ignored.
  - Digits switch back to back, each in a single edge.

## Test plan
Parameters: `DIGIT_TICKS`=4, `BLANK_TICKS`=2, macro defined unless noted.

- Reset: hold `rst_n`=0 with `enable`=1 → `anode`=4'hF, `seg`=7'h7F, `frame_done`=0 throughout.
- Idle load then enable: load 1,2,3,4, then raise `enable`. Required:
  - `anode`=0111, `seg`=1111001 for 4 cycles, then 2 cycles dark.
  - Then `anode`=1011, `seg`=0100100, then C=3 and D=4 in turn.
  - `frame_done` pulses 24 cycles after the first lit cycle.
- Mid-frame load: during B's slot, load A,B,C,D=F. Required: current frame still shows 1,2,3,4; next frame shows `seg`=0001110 on every digit.
- Load coincident with boundary, and double load in one frame → last loaded values appear in the next frame.
- Macro undefined: same stimulus → no dark cycles, frame period 16, exactly one anode low every cycle.
- Disable mid-slot at digit C, then re-enable. Required:
  - Next edge is dark.
  - On re-enable, lighting restarts at `anode`=0111.
  - Async reset mid-BLANK clears all outputs with no clock.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a 4-digit seven-segment display.
// Latency: all outputs registered; a load shows at the next frame boundary (next cycle in IDLE).
// Backpressure: none; load is a fire-and-forget strobe, later loads overwrite pending data.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   enable                high = scan, low = dark (IDLE)
//   load, din_a..din_d    one-cycle capture strobe and hex digit values (A leftmost)
//   seg[6:0]              active-low cathodes, bit 6 = g .. bit 0 = a
//   anode[3:0]            active-low digit enables, A -> anode[3] .. D -> anode[0]
//   digit_sel[1:0]        lit or most recently lit digit (0 = A)
//   frame_done            one-cycle pulse in the first cycle of each new frame
//
// Build option: define SEG_SCAN_BLANK_EN to insert a BLANK_TICKS all-off gap after
// every digit (anti-ghosting). Without it digits switch back to back.
module seg_scan_ctrl #(
  parameter int DIGIT_TICKS = 100000,
  parameter int BLANK_TICKS = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       load,
  input  logic [3:0] din_a,
  input  logic [3:0] din_b,
  input  logic [3:0] din_c,
  input  logic [3:0] din_d,
  output logic [6:0] seg,
  output logic [3:0] anode,
  output logic [1:0] digit_sel,
  output logic       frame_done
);

  localparam int MAX_TICKS = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
  localparam int CW = $clog2(MAX_TICKS + 1);
  localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_TICKS - 1);

`ifdef SEG_SCAN_BLANK_EN
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_TICKS - 1);
  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHOW} state_t;
`endif

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [1:0]      dsel_nxt;
  logic [3:0][3:0] disp, disp_nxt;   // index 0 = digit A
  logic [3:0][3:0] pend, pend_nxt;
  logic            pend_valid, pend_valid_nxt;
  logic [6:0]      seg_nxt;
  logic [3:0]      anode_nxt;
  logic            frame_done_nxt;
  logic            advance, boundary, to_idle;
  logic [3:0][3:0] din_all;

  assign din_all = {din_d, din_c, din_b, din_a};

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    dsel_nxt       = digit_sel;
    disp_nxt       = disp;
    pend_nxt       = pend;
    pend_valid_nxt = pend_valid;
    advance        = 1'b0;
    boundary       = 1'b0;
    to_idle        = 1'b0;

    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = SHOW;
          dsel_nxt  = 2'd0;
          cnt_nxt   = '0;
        end
      end
      SHOW: begin
        if (!enable) begin
          to_idle = 1'b1;
        end else if (cnt == DIGIT_LAST) begin
`ifdef SEG_SCAN_BLANK_EN
          state_nxt = BLANK;
          cnt_nxt   = '0;
`else
          advance   = 1'b1;
`endif
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
`ifdef SEG_SCAN_BLANK_EN
      BLANK: begin
        if (!enable) begin
          to_idle = 1'b1;
        end else if (cnt == BLANK_LAST) begin
          advance = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase

    if (advance) begin
      state_nxt = SHOW;
      cnt_nxt   = '0;
      dsel_nxt  = digit_sel + 2'd1;
      boundary  = (digit_sel == 2'd3);
    end
    if (to_idle) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end

    // Double buffering: a load at a commit point bypasses pend (newest data wins).
    if (state == IDLE) begin
      if (load) disp_nxt = din_all;
    end else if (boundary || to_idle) begin
      if (load) disp_nxt = din_all;
      else if (pend_valid) disp_nxt = pend;
      pend_valid_nxt = 1'b0;
    end else if (load) begin
      pend_nxt       = din_all;
      pend_valid_nxt = 1'b1;
    end

    frame_done_nxt = boundary;

    // Decode from the post-edge digit and data so a lit anode never pairs with stale segments.
    if (state_nxt == SHOW) begin
      seg_nxt   = hex7(disp_nxt[dsel_nxt]);
      anode_nxt = ~(4'b1000 >> dsel_nxt);
    end else begin
      seg_nxt   = 7'h7F;
      anode_nxt = 4'hF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      digit_sel  <= 2'd0;
      disp       <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
      seg        <= 7'h7F;
      anode      <= 4'hF;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      digit_sel  <= dsel_nxt;
      disp       <= disp_nxt;
      pend       <= pend_nxt;
      pend_valid <= pend_valid_nxt;
      seg        <= seg_nxt;
      anode      <= anode_nxt;
      frame_done <= frame_done_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;
  localparam int DT = 4;
  localparam int BT = 2;
`ifdef SEG_SCAN_BLANK_EN
  localparam int GAP = BT;
`else
  localparam int GAP = 0;
`endif
  localparam int SLOT  = DT + GAP;
  localparam int FRAME = 4 * SLOT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       load = 1'b0;
  logic [3:0] din_a = 4'h0, din_b = 4'h0, din_c = 4'h0, din_d = 4'h0;
  logic [6:0] seg;
  logic [3:0] anode;
  logic [1:0] digit_sel;
  logic       frame_done;

  seg_scan_ctrl #(.DIGIT_TICKS(DT), .BLANK_TICKS(BT)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
    .din_a(din_a), .din_b(din_b), .din_c(din_c), .din_d(din_d),
    .seg(seg), .anode(anode), .digit_sel(digit_sel), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  logic [6:0] dec_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Reference model: position in the frame is derived from cycles since the
  // first lit cycle; each frame shows whatever was loaded last at its start.
  bit         m_active = 0;
  int         m_t = 0;
  logic [3:0] m_latest [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
  logic [3:0] m_shown  [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
  logic [6:0] exp_seg = 7'h7F;
  logic [3:0] exp_anode = 4'hF;
  logic       exp_fd = 1'b0;
  logic [1:0] exp_dsel = 2'd0;

  task automatic model_out();
    int p, d, off;
    if (!m_active) begin
      exp_seg = 7'h7F; exp_anode = 4'hF; exp_fd = 1'b0;
    end else begin
      p = m_t % FRAME; d = p / SLOT; off = p % SLOT;
      exp_dsel = d[1:0];
      exp_fd   = (p == 0) && (m_t > 0);
      if (off < DT) begin
        exp_anode = ~(4'b1000 >> d);
        exp_seg   = dec_tab[m_shown[d]];
      end else begin
        exp_anode = 4'hF; exp_seg = 7'h7F;
      end
    end
  endtask

  task automatic step(input logic en, input logic ld, input logic [15:0] v);
    enable = en; load = ld;
    din_a = v[15:12]; din_b = v[11:8]; din_c = v[7:4]; din_d = v[3:0];
    @(posedge clk);
    if (ld) for (int i = 0; i < 4; i++) m_latest[i] = v[15-4*i -: 4];
    if (!m_active) begin
      if (en) begin m_active = 1; m_t = 0; m_shown = m_latest; end
    end else if (!en) begin
      m_active = 0; m_shown = m_latest;
    end else begin
      m_t++;
      if (m_t % FRAME == 0) m_shown = m_latest;
    end
    model_out();
    #1 load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (seg !== 7'h7F || anode !== 4'hF || frame_done !== 1'b0 || digit_sel !== 2'd0) begin
        n_fail++;
        $display("FAIL reset c%0d: seg=%b anode=%b fd=%b dsel=%0d, want 1111111 1111 0 0",
                 c, seg, anode, frame_done, digit_sel);
      end
    end
    enable = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_idle_load_enable();
    step(0, 1, 16'h1234);
    n_cmp++;
    if (seg !== 7'h7F || anode !== 4'hF) begin
      n_fail++; $display("FAIL idle_dark: seg=%b anode=%b, want 1111111 1111", seg, anode);
    end
    step(1, 0, 16'h0);
    n_cmp++;
    if (anode !== 4'b0111 || seg !== 7'b1111001) begin
      n_fail++; $display("FAIL first_lit: seg=%b anode=%b, want 1111001 0111", seg, anode);
    end
    for (int c = 0; c < 2 * FRAME; c++) begin
      step(1, 0, 16'h0);
      n_cmp++;
      if (seg !== exp_seg || anode !== exp_anode || frame_done !== exp_fd || digit_sel !== exp_dsel) begin
        n_fail++;
        $display("FAIL scan t=%0d: seg=%b anode=%b fd=%b dsel=%0d, want %b %b %b %0d",
                 m_t, seg, anode, frame_done, digit_sel, exp_seg, exp_anode, exp_fd, exp_dsel);
      end
    end
  endtask

  task automatic test_mid_frame_load();
    for (int c = 0; c < FRAME && !((m_t % FRAME) / SLOT == 1 && (m_t % SLOT) == 1); c++)
      step(1, 0, 16'h0);
    step(1, 1, 16'hFFFF);
    for (int c = 0; c < 2 * FRAME; c++) begin
      step(1, 0, 16'h0);
      n_cmp++;
      if (seg !== exp_seg || anode !== exp_anode || frame_done !== exp_fd || digit_sel !== exp_dsel) begin
        n_fail++;
        $display("FAIL midload t=%0d: seg=%b anode=%b fd=%b dsel=%0d, want %b %b %b %0d",
                 m_t, seg, anode, frame_done, digit_sel, exp_seg, exp_anode, exp_fd, exp_dsel);
      end
    end
  endtask

  task automatic test_boundary_and_double_load();
    for (int c = 0; c < FRAME && ((m_t + 1) % FRAME) != 0; c++) step(1, 0, 16'h0);
    step(1, 1, 16'($urandom));
    for (int c = 0; c < FRAME + 2; c++) begin
      step(1, (c == 3 || c == 9), 16'($urandom));
      n_cmp++;
      if (seg !== exp_seg || anode !== exp_anode || frame_done !== exp_fd || digit_sel !== exp_dsel) begin
        n_fail++;
        $display("FAIL bndload t=%0d: seg=%b anode=%b fd=%b dsel=%0d, want %b %b %b %0d",
                 m_t, seg, anode, frame_done, digit_sel, exp_seg, exp_anode, exp_fd, exp_dsel);
      end
    end
  endtask

  task automatic test_disable_reenable();
    for (int c = 0; c < FRAME && !((m_t % FRAME) / SLOT == 2 && (m_t % SLOT) == 1); c++)
      step(1, 0, 16'h0);
    step(1, 1, 16'h9A5C);
    step(0, 0, 16'h0);
    n_cmp++;
    if (seg !== 7'h7F || anode !== 4'hF || frame_done !== 1'b0) begin
      n_fail++; $display("FAIL disable_dark: seg=%b anode=%b fd=%b, want 1111111 1111 0", seg, anode, frame_done);
    end
    step(0, 0, 16'h0);
    step(1, 0, 16'h0);
    n_cmp++;
    if (anode !== 4'b0111 || seg !== 7'b0010000 || digit_sel !== 2'd0) begin
      n_fail++; $display("FAIL reenable: seg=%b anode=%b dsel=%0d, want 0010000 0111 0", seg, anode, digit_sel);
    end
    for (int c = 0; c < FRAME; c++) begin
      step(1, 0, 16'h0);
      n_cmp++;
      if (seg !== exp_seg || anode !== exp_anode || frame_done !== exp_fd || digit_sel !== exp_dsel) begin
        n_fail++;
        $display("FAIL after_reen t=%0d: seg=%b anode=%b fd=%b dsel=%0d, want %b %b %b %0d",
                 m_t, seg, anode, frame_done, digit_sel, exp_seg, exp_anode, exp_fd, exp_dsel);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      step(($urandom_range(0, 24) != 0), ($urandom_range(0, 6) == 0), 16'($urandom));
      n_cmp++;
      if (seg !== exp_seg || anode !== exp_anode || frame_done !== exp_fd ||
          (m_active && digit_sel !== exp_dsel)) begin
        n_fail++;
        $display("FAIL random c%0d: seg=%b anode=%b fd=%b dsel=%0d, want %b %b %b %0d",
                 c, seg, anode, frame_done, digit_sel, exp_seg, exp_anode, exp_fd, exp_dsel);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 3 * FRAME && !(m_active && (m_t % SLOT) == 1); c++) step(1, 0, 16'h0);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (seg !== 7'h7F || anode !== 4'hF || frame_done !== 1'b0 || digit_sel !== 2'd0) begin
      n_fail++; $display("FAIL async_reset: seg=%b anode=%b fd=%b dsel=%0d, want 1111111 1111 0 0",
                         seg, anode, frame_done, digit_sel);
    end
    @(posedge clk); #1;
    enable = 1'b0; rst_n = 1'b1;
    m_active = 0;
    for (int i = 0; i < 4; i++) begin m_latest[i] = 4'h0; m_shown[i] = 4'h0; end
    step(1, 0, 16'h0);
    n_cmp++;
    if (anode !== 4'b0111 || seg !== 7'b1000000) begin
      n_fail++; $display("FAIL post_reset_data: seg=%b anode=%b, want 1000000 0111", seg, anode);
    end
  endtask

  initial begin
    test_reset();
    test_idle_load_enable();
    test_mid_frame_load();
    test_boundary_and_double_load();
    test_disable_reenable();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
